// File: rtl/fir_param_pkg.sv
// Shared helpers for fir_param_filter: accumulator sizing, unity coefficient,
// and the saturate/wrap reduction used on the scaled filter sum.
package fir_param_pkg;

    localparam int WIDE_W = 128;
    localparam logic [WIDE_W-1:0] WIDE_ONE = {{(WIDE_W-1){1'b0}}, 1'b1};

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic logic signed [WIDE_W-1:0] unity_coef(input int coef_frac);
        return WIDE_ONE << coef_frac;
    endfunction

    // Callers keep the low data_w bits, so the non-saturating path is a plain wrap.
    function automatic logic signed [WIDE_W-1:0] fit_data(input logic signed [WIDE_W-1:0] val,
                                                          input int data_w,
                                                          input bit sat_en);
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        max_v = (WIDE_ONE << (data_w - 1)) - WIDE_ONE;
        min_v = ~max_v;
        if (sat_en && (val > max_v)) begin
            return max_v;
        end else if (sat_en && (val < min_v)) begin
            return min_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/fir_param_filter_tap.sv
// One filter tap: writable coefficient register and its product with a history sample.
module fir_param_tap
    import fir_param_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int ADDR_W    = 5,
    parameter int IDX       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_we,
    input  logic [ADDR_W-1:0]          coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic signed [DATA_W-1:0]   x,
    output logic signed [DATA_W+COEF_W-1:0] prod
);

    localparam logic signed [COEF_W-1:0] RST_COEF =
        (IDX == 0) ? COEF_W'(unity_coef(COEF_FRAC)) : {COEF_W{1'b0}};

    logic signed [COEF_W-1:0] coef_r;
    logic                     hit_s;

    // Address decode and product; the product sees the pre-write coefficient.
    always_comb begin
        hit_s = coef_we && (coef_addr == ADDR_W'(IDX));
        prod  = x * coef_r;
    end

    // Coefficient register, reset to unity on tap 0 and zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_r <= RST_COEF;
        end else if (hit_s) begin
            coef_r <= coef_wdata;
        end
    end

endmodule

// File: rtl/fir_param_filter.sv
// Parameterised direct-form FIR with writable coefficients and a fill-gated valid.
// Define FIR_PARAM_SAT_EN to saturate the output instead of wrapping it.
module fir_param_filter
    import fir_param_pkg::*;
#(
    parameter int TAPS      = 32,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_valid,
    input  logic [DATA_W-1:0]        data,
    input  logic                     flush,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     fir_valid,
    output logic [DATA_W-1:0]        fir_d
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int CNT_W  = $clog2(TAPS + 1);
`ifdef FIR_PARAM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic signed [DATA_W-1:0] hist_r     [TAPS];
    logic signed [DATA_W-1:0] hist_nxt_s [TAPS];
    logic signed [PROD_W-1:0] prod_s     [TAPS];
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [WIDE_W-1:0] scaled_s;
    logic [DATA_W-1:0]        result_s;
    logic [CNT_W-1:0]         fill_r;
    logic [CNT_W-1:0]         fill_nxt_s;
    logic                     full_nxt_s;
    logic                     fir_valid_r;
    logic [DATA_W-1:0]        fir_d_r;

    // Post-shift history: the result is computed on the history as it will be after this edge.
    always_comb begin
        hist_nxt_s[0] = data;
        for (int k = 1; k < TAPS; k++) begin
            hist_nxt_s[k] = hist_r[k-1];
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_tap
        fir_param_tap #(
            .DATA_W    (DATA_W),
            .COEF_W    (COEF_W),
            .COEF_FRAC (COEF_FRAC),
            .ADDR_W    (ADDR_W),
            .IDX       (g)
        ) u_tap (
            .clk        (clk),
            .rst_n      (rst_n),
            .coef_we    (coef_we),
            .coef_addr  (coef_addr),
            .coef_wdata (coef_wdata),
            .x          (hist_nxt_s[g]),
            .prod       (prod_s[g])
        );
    end

    // Adder tree, floor scaling by COEF_FRAC, reduction to DATA_W and fill-count update.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            acc_s = acc_s + ACC_W'(prod_s[k]);
        end
        scaled_s = WIDE_W'(acc_s) >>> COEF_FRAC;
        result_s = DATA_W'(fit_data(scaled_s, DATA_W, SAT_EN));
        if (fill_r == CNT_W'(TAPS)) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        full_nxt_s = (fill_nxt_s == CNT_W'(TAPS));
    end

    // History, fill count and registered result; flush wins over an offered sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                hist_r[k] <= {DATA_W{1'b0}};
            end
            fill_r      <= {CNT_W{1'b0}};
            fir_valid_r <= 1'b0;
            fir_d_r     <= {DATA_W{1'b0}};
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                hist_r[k] <= {DATA_W{1'b0}};
            end
            fill_r      <= {CNT_W{1'b0}};
            fir_valid_r <= 1'b0;
        end else if (data_valid) begin
            hist_r      <= hist_nxt_s;
            fill_r      <= fill_nxt_s;
            fir_valid_r <= full_nxt_s;
            if (full_nxt_s) begin
                fir_d_r <= result_s;
            end
        end else begin
            fir_valid_r <= 1'b0;
        end
    end

    assign fir_valid = fir_valid_r;
    assign fir_d     = fir_d_r;

endmodule

// File: doc/fir_param_filter.md
FIR_PARAM_FILTER -- requirements
Module: fir_param_filter

Interface
REQ-001 Parameter TAPS, default 32: number of filter taps; legal range 2..64.
REQ-002 Parameter DATA_W, default 16: signed width of input samples and of fir_d.
REQ-003 Parameter COEF_W, default 20: signed coefficient width.
REQ-004 Parameter COEF_FRAC, default 16: coefficient fractional bits, so 1.0 = 2^COEF_FRAC.
REQ-005 One clock and an asynchronous active-low reset; the ports SHALL be named clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 data_valid  input  1  a sample is offered this cycle.
REQ-009 data  input  DATA_W  signed input sample.
REQ-010 flush  input  1  synchronous clear of the sample history.
REQ-011 coef_we  input  1  coefficient write strobe.
REQ-012 coef_addr  input  clog2(TAPS)  coefficient index k.
REQ-013 coef_wdata  input  COEF_W  signed coefficient value.
REQ-014 fir_valid  output  1  fir_d holds a valid result this cycle.
REQ-015 fir_d  output  DATA_W  signed filter output.

Function
REQ-016 Each cycle with data_valid=1 and flush=0, the block SHALL accept one sample: it shifts data into history x[0] and moves x[k-1] to x[k].
REQ-017 On acceptance, the block SHALL compute y = sum over k=0..TAPS-1 of c[k]*x[k], using the post-shift history, with a full-precision accumulator of DATA_W+COEF_W+clog2(TAPS) bits.
REQ-018 Scaling: the block SHALL arithmetic-shift y right by COEF_FRAC bits (truncation toward minus infinity) and then reduce it to DATA_W bits.
REQ-019 Latency: fir_d and fir_valid SHALL be registered and appear exactly 1 cycle after the accepting edge.
REQ-020 A saturating fill counter (0..TAPS) SHALL increment on each acceptance; fir_valid SHALL be 1 only in the cycle after an acceptance that brings the count to TAPS or leaves it at TAPS.
REQ-021 fir_valid SHALL be 0 in every other cycle, including cycles after data_valid=0.
REQ-022 fir_d SHALL hold its last value while fir_valid=0.
REQ-023 Gaps on data_valid SHALL NOT clear the history or the fill count: gapped and gapless streams SHALL produce identical result sequences.
REQ-024 flush=1 SHALL clear all x[k] and the fill count to 0 and drive fir_valid to 0 on the next cycle.
REQ-025 flush SHALL take priority over a simultaneous data_valid; that sample is dropped.
REQ-026 Coefficients SHALL be retained across flush.
REQ-027 coef_we=1 SHALL write c[coef_addr] at the clock edge.
REQ-028 A sample accepted in the same cycle as a coefficient write SHALL use the old coefficient; the new value applies from the next acceptance.
REQ-029 coef_addr >= TAPS SHALL be ignored.

Reset
REQ-030 While rst_n=0, the block SHALL clear all x[k], the fill count, fir_valid and fir_d to 0, and set c[0] = 2^COEF_FRAC (unity pass-through) and c[k] = 0 for k >= 1.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight results; the first valid output after release SHALL require TAPS new acceptances.

Configuration
REQ-032 With macro FIR_PARAM_SAT_EN defined, the reduction to DATA_W SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-033 Without FIR_PARAM_SAT_EN, the reduction SHALL keep the low DATA_W bits (two's-complement wrap).

Structure
REQ-034 Package fir_param_pkg SHALL hold the accumulator-width function, the unity-coefficient constant function, and the saturate/wrap helper function.
REQ-035 Sub-module fir_param_tap SHALL implement one tap: coefficient register, write decode and product; the top SHALL instantiate TAPS copies and an adder tree.

Verification (TAPS=32, DATA_W=16, COEF_W=20, COEF_FRAC=16)
REQ-036 Reset with default coefficients, then 40 consecutive samples of 0x0100 -> fir_valid first high one cycle after the 32nd acceptance, with fir_d=0x0100 on every valid cycle.
REQ-037 All c[k]=0x01000, constant input 0x0100 -> fir_d=0x0200 once fir_valid is high.
REQ-038 All c[k]=0x10000, constant input 0x7FFF -> fir_d=0x7FFF with FIR_PARAM_SAT_EN defined, and fir_d=0xFFE0 without it.
REQ-039 Same 40-sample ramp fed with random 1-3 cycle data_valid gaps -> fir_d sequence identical to the gapless run, and fir_valid=0 in every gap cycle.
REQ-040 Flush after 35 samples -> fir_valid=0 until 32 further acceptances; an impulse 0x0100 then reproduces the loaded coefficients scaled on fir_d; flush together with data_valid -> that sample is dropped.
REQ-041 rst_n pulsed low mid-stream after coefficient loads -> fir_d=0 and fir_valid=0 immediately, and the coefficients return to unity pass-through.
